// File: rtl/adder_arbiter_if.sv
// Handshake bundle for the shared-adder arbiter.
// The requester side drives the master modport; the arbiter uses the slave modport.
interface adder_arbiter_if #(
   parameter int WIDTH = 5,
   parameter int NREQ  = 4
);
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_x;
   logic [NREQ*WIDTH-1:0] req_y;
   logic [NREQ-1:0]       req_sub;
   logic                  res_valid;
   logic                  res_ready;
   logic [WIDTH-1:0]      res_s;
   logic                  res_co;
   logic [IDW-1:0]        res_id;

   modport master (
      output req_valid, req_x, req_y, req_sub, res_ready,
      input  req_ready, res_valid, res_s, res_co, res_id
   );

   modport slave (
      input  req_valid, req_x, req_y, req_sub, res_ready,
      output req_ready, res_valid, res_s, res_co, res_id
   );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one adder among NREQ requesters, one-entry result register.
// Define ADDER_ARB_SUB_EN to enable per-requester subtract (X + ~Y + 1).
module adder_arbiter #(
   parameter int WIDTH = 5,
   parameter int NREQ  = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   adder_arbiter_if.slave  bus
);
   localparam int IDW = $clog2(NREQ);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [IDW-1:0]   last_grant;
   logic [IDW-1:0]   grant;
   logic             found;
   logic             accept;
   logic             xfer;
   logic             sub;
   logic [WIDTH-1:0] gx;
   logic [WIDTH-1:0] gy;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] s_q;
   logic             co_q;
   logic [IDW-1:0]   id_q;

   // Search starts one past the last winner and wraps.
   always_comb begin
      grant = last_grant;
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!found && bus.req_valid[(int'(last_grant) + k) % NREQ]) begin
            found = 1'b1;
            grant = IDW'((int'(last_grant) + k) % NREQ);
         end
      end
   end

   assign accept = (state == EMPTY) || bus.res_ready;
   assign xfer   = accept && found;

   always_comb begin
      bus.req_ready = '0;
      if (xfer) bus.req_ready[grant] = 1'b1;
   end

   assign gx = bus.req_x[int'(grant)*WIDTH +: WIDTH];
   assign gy = bus.req_y[int'(grant)*WIDTH +: WIDTH];

`ifdef ADDER_ARB_SUB_EN
   assign sub = bus.req_sub[grant];
`else
   wire unused_sub = ^bus.req_sub;
   assign sub = 1'b0;
`endif

   // Subtract folds into the add as inverted Y plus carry-in.
   assign sum = {1'b0, gx}
              + {1'b0, (sub ? ~gy : gy)}
              + (WIDTH+1)'(sub);

   always_comb begin
      state_nxt = state;
      unique case (state)
         EMPTY: if (xfer) state_nxt = FULL;
         FULL:  if (bus.res_ready && !xfer) state_nxt = EMPTY;
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= EMPTY;
         last_grant <= IDW'(NREQ-1);
         s_q        <= '0;
         co_q       <= 1'b0;
         id_q       <= '0;
      end else begin
         state <= state_nxt;
         if (xfer) begin
            last_grant <= grant;
            s_q        <= sum[WIDTH-1:0];
            co_q       <= sum[WIDTH];
            id_q       <= grant;
         end
      end
   end

   assign bus.res_valid = (state == FULL);
   assign bus.res_s     = s_q;
   assign bus.res_co    = co_q;
   assign bus.res_id    = id_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed-vector bench for adder_arbiter (WIDTH=5, NREQ=4).
// Expected values are hand-computed; subtract vectors depend on ADDER_ARB_SUB_EN.
module tb_adder_arbiter;
   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_bad;

   adder_arbiter_if #(.WIDTH(5), .NREQ(4)) bus ();

   adder_arbiter #(.WIDTH(5), .NREQ(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [4:0] x, input logic [4:0] y);
      bus.req_x[i*5 +: 5] = x;
      bus.req_y[i*5 +: 5] = y;
   endtask

   int exp_id [5] = '{0, 1, 2, 3, 0};
   int exp_s  [5] = '{3, 6, 9, 12, 3};

   initial begin
      n_vec = 0;
      n_bad = 0;
      rst_n = 1'b0;
      bus.req_valid = '0;
      bus.req_sub   = '0;
      bus.req_x     = '0;
      bus.req_y     = '0;
      bus.res_ready = 1'b1;
      #3;
      check("rst_valid", 32'(bus.res_valid), 0);
      check("rst_s",     32'(bus.res_s), 0);
      check("rst_co",    32'(bus.res_co), 0);
      check("rst_id",    32'(bus.res_id), 0);
      check("rst_ready", 32'(bus.req_ready), 0);
      #4;
      rst_n = 1'b1;

      // basic add from requester 0
      set_op(0, 5'd1, 5'd1);
      bus.req_valid = 4'b0001;
      #1;
      check("r0_ready", 32'(bus.req_ready), 32'b0001);
      step();
      check("r0_valid", 32'(bus.res_valid), 1);
      check("r0_s",     32'(bus.res_s), 2);
      check("r0_co",    32'(bus.res_co), 0);
      check("r0_id",    32'(bus.res_id), 0);

      // overflow on requester 2, back-to-back
      set_op(2, 5'd31, 5'd31);
      bus.req_valid = 4'b0100;
      #1;
      check("r2_ready", 32'(bus.req_ready), 32'b0100);
      step();
      check("ovf_s",  32'(bus.res_s), 30);
      check("ovf_co", 32'(bus.res_co), 1);
      check("ovf_id", 32'(bus.res_id), 2);
      set_op(2, 5'd1, 5'd31);
      step();
      check("wrap_s",     32'(bus.res_s), 0);
      check("wrap_co",    32'(bus.res_co), 1);
      check("wrap_valid", 32'(bus.res_valid), 1);

      // drain keeps payload
      bus.req_valid = '0;
      step();
      check("drain_valid", 32'(bus.res_valid), 0);
      check("drain_s",     32'(bus.res_s), 0);
      check("drain_co",    32'(bus.res_co), 1);
      check("drain_id",    32'(bus.res_id), 2);

      // round robin after a fresh reset
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) set_op(i, 5'(i + 3), 5'(2 * i));
      bus.req_valid = 4'b1111;
      #1;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("rr_ready%0d", i), 32'(bus.req_ready), 32'(1) << exp_id[i]);
         step();
         check($sformatf("rr_id%0d", i), 32'(bus.res_id), 32'(exp_id[i]));
         check($sformatf("rr_s%0d", i),  32'(bus.res_s), 32'(exp_s[i]));
         check($sformatf("rr_v%0d", i),  32'(bus.res_valid), 1);
      end

      // backpressure stall
      bus.req_valid = 4'b0010;
      bus.res_ready = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("stall_ready%0d", i), 32'(bus.req_ready), 0);
         check($sformatf("stall_v%0d", i),     32'(bus.res_valid), 1);
         check($sformatf("stall_id%0d", i),    32'(bus.res_id), 0);
         check($sformatf("stall_s%0d", i),     32'(bus.res_s), 3);
         step();
      end
      bus.res_ready = 1'b1;
      #1;
      check("unstall_ready", 32'(bus.req_ready), 32'b0010);
      step();
      check("unstall_v",  32'(bus.res_valid), 1);
      check("unstall_id", 32'(bus.res_id), 1);
      check("unstall_s",  32'(bus.res_s), 6);

      // subtract select
      bus.req_valid = 4'b0001;
      bus.req_sub   = 4'b0001;
      set_op(0, 5'd2, 5'd5);
      #1;
      check("sub_ready", 32'(bus.req_ready), 32'b0001);
      step();
`ifdef ADDER_ARB_SUB_EN
      check("sub1_s",  32'(bus.res_s), 29);
      check("sub1_co", 32'(bus.res_co), 0);
`else
      check("sub1_s",  32'(bus.res_s), 7);
      check("sub1_co", 32'(bus.res_co), 0);
`endif
      set_op(0, 5'd10, 5'd10);
      step();
`ifdef ADDER_ARB_SUB_EN
      check("sub2_s",  32'(bus.res_s), 0);
      check("sub2_co", 32'(bus.res_co), 1);
`else
      check("sub2_s",  32'(bus.res_s), 20);
      check("sub2_co", 32'(bus.res_co), 0);
`endif

      // reset mid-stream while full
      bus.req_sub = '0;
      #2;
      rst_n = 1'b0;
      #1;
      check("mrst_valid", 32'(bus.res_valid), 0);
      check("mrst_s",     32'(bus.res_s), 0);
      check("mrst_id",    32'(bus.res_id), 0);
      bus.req_valid = 4'b1111;
      #2;
      rst_n = 1'b1;
      #1;
      check("post_ready", 32'(bus.req_ready), 32'b0001);
      step();
      check("post_id", 32'(bus.res_id), 0);
      check("post_s",  32'(bus.res_s), 20);
      check("post_v",  32'(bus.res_valid), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter WIDTH, default 5, operand/sum width in bits.
REQ-002 Parameter NREQ, default 4, number of requesters (2..8).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  NREQ  per-requester operation request.
REQ-006 req_ready  output  NREQ  per-requester accept; one-hot or zero.
REQ-007 req_x  input  NREQ*WIDTH  flattened X operands; requester i at bits [i*WIDTH +: WIDTH].
REQ-008 req_y  input  NREQ*WIDTH  flattened Y operands; same packing as req_x.
REQ-009 req_sub  input  NREQ  per-requester subtract select; used only with ADDER_ARB_SUB_EN.
REQ-010 res_valid  output  1  result register holds a valid result.
REQ-011 res_ready  input  1  consumer accepts the result this cycle.
REQ-012 res_s  output  WIDTH  registered sum.
REQ-013 res_co  output  1  registered carry-out of the MSB stage.
REQ-014 res_id  output  clog2(NREQ)  index of the requester that owns the result.

Function
REQ-015 The block SHALL share one WIDTH-bit adder (carry-in 0 for add) among NREQ requesters, with a one-entry output register.
REQ-016 State SHALL be EMPTY (res_valid=0) or FULL (res_valid=1); accept is enabled when EMPTY, or when FULL and res_ready=1.
REQ-017 When accept is enabled and any req_valid is 1, grant SHALL go round-robin to the first valid index after last_grant, wrapping from NREQ-1 to 0.
REQ-018 req_ready[g] SHALL be 1 combinationally for the granted index g only; every other bit is 0, and all bits are 0 when accept is disabled.
REQ-019 A transfer occurs when req_valid[g] and req_ready[g] are both 1; on that edge {res_co,res_s} <= X+Y as WIDTH+1 bits, res_id <= g, last_grant <= g, and state becomes FULL.
REQ-020 Latency SHALL be 1 cycle (transfer edge to res_valid=1); throughput SHALL be 1 per cycle while res_ready=1.
REQ-021 Drain without a new transfer (FULL, res_ready=1, no valid) SHALL return the state to EMPTY; res_s, res_co and res_id keep their last values.
REQ-022 A simultaneous drain and transfer SHALL replace the result, keeping res_valid=1 with no bubble.
REQ-023 While FULL and res_ready=0, all result outputs SHALL hold stable and all req_ready bits SHALL be 0.
REQ-024 Operands SHALL stay stable while valid and not ready; no request is dropped, and every requester continuously valid is served within NREQ transfers.
REQ-025 The sum SHALL wrap modulo 2^WIDTH, with the overflow bit reported only on res_co.

Reset
REQ-026 On rst_n low, asynchronously: state=EMPTY, res_valid=0, res_s=0, res_co=0, res_id=0, last_grant=NREQ-1, so requester 0 has priority first.
REQ-027 Reset mid-operation SHALL discard any held result; no transfer occurs while rst_n is low.

Configuration
REQ-028 Macro ADDER_ARB_SUB_EN: when defined, a transfer with req_sub[g]=1 SHALL compute X + ~Y + 1, and res_co=1 means no borrow (X>=Y).
REQ-029 Without ADDER_ARB_SUB_EN, req_sub SHALL be ignored and every operation is an add with carry-in 0.

Verification
REQ-030 Reset, then req_valid=0001, X=1, Y=1, res_ready=1 -> next cycle res_valid=1, res_s=2, res_co=0, res_id=0.
REQ-031 Requester 2 with X=31, Y=31 -> res_s=30, res_co=1, res_id=2; also check X=1, Y=31 -> res_s=0, res_co=1.
REQ-032 req_valid=1111 held, res_ready=1 -> res_id sequence 0,1,2,3,0 on consecutive cycles, one-hot req_ready each cycle.
REQ-033 FULL with res_ready=0 for 3 cycles and req_valid=0010 -> req_ready=0000 and outputs stable; res_ready=1 -> transfer of requester 1 on the same edge, res_valid stays 1.
REQ-034 With ADDER_ARB_SUB_EN: X=2, Y=5, req_sub=1 -> res_s=29 (11101), res_co=0; X=10, Y=10 -> res_s=0, res_co=1. Without the macro, the same stimulus gives 7 and 20.
REQ-035 Assert rst_n=0 while FULL mid-stream -> res_valid=0 immediately; after release, requester 0 has first priority.
